demux_stream: RTL and testbench

Parametrised, registered successor to the combinational 5-to-32 decoder: routes a valid/ready data stream to one of NUM_CH output channels selected by an address (addressed mode) or by an internal wrapping pointer (sweep mode). A one-entry output register gives one cycle of latency and full throughput under backpressure. It sits between a single producer and a bank of per-channel consumers.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_stream_onehot_dec.sv | 23 ++
 rtl/demux_stream.sv | 124 ++++++++++++
 tb/tb_demux_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux_stream stream router.
package demux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic MODE_ADDR  = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    // Select width never collapses to zero bits, even for two channels.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_stream_onehot_dec.sv
// Combinational index -> one-hot decoder with an in-range flag; NUM_CH need not be a power of two.
module onehot_dec
    import demux_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [SEL_W-1:0]  idx,
    output logic [NUM_CH-1:0] onehot,
    output logic              valid_idx
);

    localparam logic [SEL_W:0] NUM_CH_W = NUM_CH[SEL_W:0];

    always_comb begin
        valid_idx = ({1'b0, idx} < NUM_CH_W);
        onehot    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = valid_idx && (idx == i[SEL_W-1:0]);
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered valid/ready demux: routes each beat to one of NUM_CH channels (addressed or sweep).
// Build option DEMUX_ACTIVE_LOW_EN makes out_onehot active-low (all-ones when empty).
module demux_stream
    import demux_pkg::*;
#(
    parameter  int NUM_CH = 32,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_onehot,
    output logic              err,
    output logic [SEL_W-1:0]  ptr
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]   vld_q, vld_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                err_q, err_d;

    logic [SEL_W-1:0]    tgt;
    logic [NUM_CH-1:0]   tgt_onehot;
    logic                tgt_ok;
    logic                held_ready;
    logic                accept;
    logic                drain;

    assign tgt = (mode == MODE_SWEEP) ? ptr_q : in_sel;

    onehot_dec #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_dec (
        .idx       (tgt),
        .onehot    (tgt_onehot),
        .valid_idx (tgt_ok)
    );

    // vld_q is zero when empty, so masking out_ready with it selects the held channel's ready.
    assign held_ready = |(out_ready & vld_q);
    assign in_ready   = en && ((state_q == ST_EMPTY) || held_ready);
    assign accept     = in_valid && in_ready;
    assign drain      = (state_q == ST_FULL) && held_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;

        if (accept && (mode == MODE_SWEEP)) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
        if (accept && !tgt_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept && tgt_ok) begin
                    state_d = ST_FULL;
                    data_d  = in_data;
                    vld_d   = tgt_onehot;
                end
            end
            ST_FULL: begin
                // In FULL an accept implies the held beat drains in the same cycle.
                if (accept && tgt_ok) begin
                    data_d = in_data;
                    vld_d  = tgt_onehot;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                    vld_d   = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                vld_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            vld_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign err       = err_q;
    assign ptr       = ptr_q;

`ifdef DEMUX_ACTIVE_LOW_EN
    assign out_onehot = ~vld_q;
`else
    assign out_onehot = vld_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Randomised and directed bench for demux_stream (NUM_CH=20) against a queue-based reference model.
module tb_demux_stream;

    localparam int NUM_CH = 20;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready = '0;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] out_onehot;
    logic              err;
    logic [SEL_W-1:0]  ptr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t hold[$];
    int    m_ptr = 0;
    bit    m_err = 1'b0;

    demux_stream #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_onehot (out_onehot),
        .err        (err),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH-1:0] bit_at(input int ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_valid();
        if (hold.size() == 0) return '0;
        return bit_at(hold[0].ch);
    endfunction

    function automatic logic [NUM_CH-1:0] exp_onehot(input logic [NUM_CH-1:0] v);
`ifdef DEMUX_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic logic m_ready();
        return en && ((hold.size() == 0) || out_ready[hold[0].ch]);
    endfunction

    task automatic model_reset();
        hold.delete();
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic set_in(input logic e, input logic m, input logic v, input int s,
                          input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] r);
        en        = e;
        mode      = m;
        in_valid  = v;
        in_sel    = s[SEL_W-1:0];
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance one clock and apply the stream rules to the reference model.
    task automatic tick();
        logic  rdy, acc, drained;
        int    tgt;
        beat_t b;
        rdy     = m_ready();
        acc     = in_valid && rdy;
        tgt     = mode ? m_ptr : int'(in_sel);
        drained = (hold.size() != 0) && out_ready[hold[0].ch];
        @(posedge clk);
        m_err = acc && (tgt >= NUM_CH);
        if (drained) void'(hold.pop_front());
        if (acc && tgt < NUM_CH) begin
            b.ch   = tgt;
            b.data = in_data;
            hold.push_back(b);
        end
        if (acc && mode) m_ptr = (m_ptr + 1) % NUM_CH;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        en = 1'b1;
        #1;
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
        n_checks++; if (out_onehot !== exp_onehot('0)) begin n_fail++; $display("FAIL reset_onehot got %h want %h", out_onehot, exp_onehot('0)); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (ptr !== '0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", ptr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_addressed();
        set_in(1, 0, 1, 5, 8'hA5, '1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== bit_at(5)) begin n_fail++; $display("FAIL addr_out_valid got %h want %h", out_valid, bit_at(5)); end
        n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL addr_out_data got %h want a5", out_data); end
        n_checks++; if (out_onehot !== exp_onehot(bit_at(5))) begin n_fail++; $display("FAIL addr_onehot got %h want %h", out_onehot, exp_onehot(bit_at(5))); end
        set_in(1, 0, 0, 0, 8'h00, '1);
        tick();
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL addr_drain got %h want 0", out_valid); end
        n_checks++; if (out_onehot !== exp_onehot('0)) begin n_fail++; $display("FAIL addr_idle_onehot got %h want %h", out_onehot, exp_onehot('0)); end
    endtask

    task automatic test_backpressure();
        set_in(1, 0, 1, 5, 8'hA5, ~bit_at(5));
        tick();
        set_in(1, 0, 1, 7, 8'h3C, ~bit_at(5));
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
            tick();
            n_checks++; if (out_valid !== bit_at(5) || out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_hold cyc %0d got %h/%h want %h/a5", i, out_valid, out_data, bit_at(5)); end
        end
        set_in(1, 0, 1, 7, 8'h3C, '1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== bit_at(7) || out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_b2b got %h/%h want %h/3c", out_valid, out_data, bit_at(7)); end
        set_in(1, 0, 0, 0, 8'h00, '1);
        tick();
    endtask

    task automatic test_out_of_range();
        int p0;
        p0 = m_ptr;
        set_in(1, 0, 1, 25, 8'h77, '1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL oor_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", err); end
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL oor_out_valid got %h want 0", out_valid); end
        n_checks++; if (int'(ptr) !== p0) begin n_fail++; $display("FAIL oor_ptr got %0d want %0d", ptr, p0); end
        set_in(1, 0, 0, 0, 8'h00, '1);
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got %b want 0", err); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 22; i++) begin
            set_in(1, 1, 1, 31, 8'(i + 8'h40), '1);
            tick();
            n_checks++; if (out_valid !== bit_at(i % NUM_CH) || out_data !== 8'(i + 8'h40)) begin n_fail++; $display("FAIL sweep_beat %0d got %h/%h want %h/%h", i, out_valid, out_data, bit_at(i % NUM_CH), 8'(i + 8'h40)); end
            n_checks++; if (int'(ptr) !== (i + 1) % NUM_CH) begin n_fail++; $display("FAIL sweep_ptr %0d got %0d want %0d", i, ptr, (i + 1) % NUM_CH); end
        end
        n_checks++; if (ptr !== 5'd2) begin n_fail++; $display("FAIL sweep_final_ptr got %0d want 2", ptr); end
        set_in(1, 1, 0, 0, 8'h00, '1);
        tick();
    endtask

    task automatic test_enable_reset();
        set_in(0, 0, 1, 3, 8'h11, '1);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_in_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== '0 || int'(ptr) !== m_ptr) begin n_fail++; $display("FAIL en_no_change got %h/%0d want 0/%0d", out_valid, ptr, m_ptr); end
        set_in(1, 0, 1, 3, 8'h11, '0);
        tick();
        set_in(1, 0, 0, 0, 8'h00, '0);
        n_checks++; if (out_valid !== bit_at(3)) begin n_fail++; $display("FAIL rst_pre_full got %h want %h", out_valid, bit_at(3)); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== '0 || ptr !== '0) begin n_fail++; $display("FAIL rst_async got %h/%0d want 0/0", out_valid, ptr); end
        n_checks++; if (out_onehot !== exp_onehot('0) || out_data !== '0) begin n_fail++; $display("FAIL rst_async_regs got %h/%h want %h/0", out_onehot, out_data, exp_onehot('0)); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < 400; i++) begin
            r = NUM_CH'($urandom | $urandom);
            set_in(($urandom % 8) != 0, 1'($urandom), ($urandom % 4) != 0,
                   int'($urandom_range(0, 31)), 8'($urandom), r);
            n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready %0d got %b want %b", i, in_ready, m_ready()); end
            tick();
            n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_out_valid %0d got %h want %h", i, out_valid, exp_valid()); end
            n_checks++; if (out_onehot !== exp_onehot(exp_valid())) begin n_fail++; $display("FAIL rnd_onehot %0d got %h want %h", i, out_onehot, exp_onehot(exp_valid())); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err %0d got %b want %b", i, err, m_err); end
            n_checks++; if (int'(ptr) !== m_ptr) begin n_fail++; $display("FAIL rnd_ptr %0d got %0d want %0d", i, ptr, m_ptr); end
            if (hold.size() != 0) begin
                n_checks++; if (out_data !== hold[0].data) begin n_fail++; $display("FAIL rnd_out_data %0d got %h want %h", i, out_data, hold[0].data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_backpressure();
        test_out_of_range();
        test_sweep();
        test_enable_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
